// File: rtl/jtdsp16_ram_seq.sv
// DSP16 data RAM sequencer: pointer registers, post-modify, virtual shift register wrap, host port sharing.
// Optional host arbitration is enabled by defining JTDSP16_RAM_HOST_EN.
module jtdsp16_ram_seq #(
   parameter int unsigned AW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          req,
   input  logic [1:0]    op_ptr,
   input  logic [1:0]    op_mod,
   input  logic          op_wr,
   input  logic          op_z,
   input  logic [15:0]   wr_data,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_sel,
   input  logic [15:0]   cfg_din,
   input  logic [15:0]   ram_dout,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [15:0]   ram_din,
   output logic [15:0]   rd_data,
   output logic          rd_valid,
   output logic          busy,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [15:0]   host_din,
   output logic          host_gnt
);

   localparam int unsigned DW = 16;

   typedef enum logic [1:0] { IDLE, ZWR, HOST } state_t;

   state_t        state;
   logic [DW-1:0] r [0:3];
   logic [DW-1:0] rb, re, j;
   logic [1:0]    z_ptr, z_mod;
   logic          rd_pend, busy_r;

   logic [1:0]    pm_ptr, pm_mod;
   logic [DW-1:0] pm_cur, pm_val;
   logic          pm_en;
   logic          host_go;

   // Post-modify of the pointer used by this cycle's access
   always_comb begin
      pm_ptr = op_ptr;
      pm_mod = op_mod;
      if (state == ZWR) begin
         pm_ptr = z_ptr;
         pm_mod = z_mod;
      end
      pm_cur = r[pm_ptr];
      pm_en  = (state == ZWR) || (state == IDLE && req && !op_z);
      pm_val = pm_cur;
      case (pm_mod)
         2'b01:   pm_val = (re != '0 && pm_cur == re) ? rb : pm_cur + DW'(1);
         2'b10:   pm_val = pm_cur - DW'(1);
         2'b11:   pm_val = pm_cur + j;
         default: pm_val = pm_cur;
      endcase
   end

`ifdef JTDSP16_RAM_HOST_EN
   assign host_go = (state == IDLE) && !req && host_req;
   // A request arriving during a host slot must be held until the slot ends
   assign busy    = busy_r | ((state == HOST) && req);
`else
   logic unused_host;
   assign unused_host = ^{host_req, host_we, host_addr, host_din};
   assign host_go     = 1'b0;
   assign busy        = busy_r;
`endif

   assign rd_data = ram_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         for (int i = 0; i < 4; i++) r[i] <= '0;
         rb       <= '0;
         re       <= '0;
         j        <= '0;
         z_ptr    <= '0;
         z_mod    <= '0;
         ram_addr <= '0;
         ram_we   <= 1'b0;
         ram_din  <= '0;
         rd_pend  <= 1'b0;
         rd_valid <= 1'b0;
         busy_r   <= 1'b0;
         host_gnt <= 1'b0;
      end else if (cen) begin
         ram_we   <= 1'b0;
         host_gnt <= 1'b0;
         rd_pend  <= 1'b0;
         rd_valid <= rd_pend;
         if (pm_en) r[pm_ptr] <= pm_val;
         case (state)
            IDLE: begin
               if (req) begin
                  ram_addr <= r[op_ptr][AW-1:0];
                  ram_din  <= wr_data;
                  if (op_z) begin
                     rd_pend <= 1'b1;
                     busy_r  <= 1'b1;
                     z_ptr   <= op_ptr;
                     z_mod   <= op_mod;
                     state   <= ZWR;
                  end else begin
                     ram_we  <= op_wr;
                     rd_pend <= !op_wr;
                  end
               end else if (host_go) begin
                  ram_addr <= host_addr;
                  ram_we   <= host_we;
                  ram_din  <= host_din;
                  host_gnt <= 1'b1;
                  state    <= HOST;
               end
            end
            // Second half of a compound access: address is still on ram_addr
            ZWR: begin
               ram_we  <= 1'b1;
               ram_din <= wr_data;
               busy_r  <= 1'b0;
               state   <= IDLE;
            end
            HOST:    state <= IDLE;
            default: state <= IDLE;
         endcase
         // Register loads come last so they override a same-cycle post-modify
         if (cfg_we) begin
            case (cfg_sel)
               3'd0, 3'd1, 3'd2, 3'd3: r[cfg_sel[1:0]] <= cfg_din;
               3'd4:    rb <= cfg_din;
               3'd5:    re <= cfg_din;
               3'd6:    j  <= cfg_din;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtdsp16_ram_seq.sv
// Bench for jtdsp16_ram_seq: vector table of single-cycle accesses plus hand-written multi-cycle sequences.
module tb_jtdsp16_ram_seq;

   localparam int unsigned AW = 11;

   logic          clk = 1'b0;
   logic          rst, cen, req, op_wr, op_z, cfg_we;
   logic [1:0]    op_ptr, op_mod;
   logic [15:0]   wr_data, cfg_din, ram_dout, ram_din, rd_data, host_din;
   logic [2:0]    cfg_sel;
   logic [AW-1:0] ram_addr, host_addr;
   logic          ram_we, rd_valid, busy, host_req, host_we, host_gnt;

   jtdsp16_ram_seq #(.AW(AW)) dut (
      .clk(clk), .rst(rst), .cen(cen), .req(req), .op_ptr(op_ptr), .op_mod(op_mod),
      .op_wr(op_wr), .op_z(op_z), .wr_data(wr_data), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_din(cfg_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_din(ram_din), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
      .host_gnt(host_gnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input int a);
      return 16'h5A00 ^ 16'(a * 7);
   endfunction

   // Synchronous RAM: data for an address appears one cen-cycle later
   logic        mem_clr;
   logic [15:0] mem [0:2047];
   always @(posedge clk) begin
      if (mem_clr) begin
         foreach (mem[i]) mem[i] <= init_val(i);
      end else if (cen) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         ram_dout <= mem[ram_addr];
      end
   end

   logic [15:0] model_mem [0:2047];
   logic [15:0] sb [$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read-data scoreboard
   logic        mon_cen, mon_rst;
   logic [15:0] mon_exp;
   always begin
      @(posedge clk);
      mon_cen = cen;
      mon_rst = rst;
      #1;
      if (mon_cen && !mon_rst && rd_valid) begin
         if (sb.size() == 0) begin
            check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
         end else begin
            mon_exp = sb.pop_front();
            check("rd_data", 32'(rd_data), 32'(mon_exp));
         end
      end
   end

   task automatic cfg_ld(input logic [2:0] sel, input logic [15:0] din);
      req = 1'b0; cfg_we = 1'b1; cfg_sel = sel; cfg_din = din;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic dsp_rd(input logic [1:0] p, input logic [1:0] m, input logic [AW-1:0] a);
      req = 1'b1; op_z = 1'b0; op_wr = 1'b0; op_ptr = p; op_mod = m; cfg_we = 1'b0;
      sb.push_back(model_mem[a]);
      tick();
      check("rd_addr", 32'(ram_addr), 32'(a));
      check("rd_we", 32'(ram_we), 32'd0);
      req = 1'b0;
   endtask

   typedef struct {
      logic          req;
      logic [1:0]    ptr;
      logic [1:0]    mod;
      logic          wr;
      logic [15:0]   wdata;
      logic          cfg;
      logic [2:0]    sel;
      logic [15:0]   din;
      logic [AW-1:0] exp_addr;
   } vec_t;

   function automatic vec_t acc(input logic [1:0] p, input logic [1:0] m, input logic w,
                                input logic [15:0] d, input logic [AW-1:0] a);
      vec_t v;
      v = '{req: 1'b1, ptr: p, mod: m, wr: w, wdata: d, cfg: 1'b0, sel: 3'd0, din: 16'd0, exp_addr: a};
      return v;
   endfunction

   function automatic vec_t cfgv(input logic [2:0] s, input logic [15:0] d);
      vec_t v;
      v = '{req: 1'b0, ptr: 2'd0, mod: 2'd0, wr: 1'b0, wdata: 16'd0, cfg: 1'b1, sel: s, din: d, exp_addr: '0};
      return v;
   endfunction

   vec_t vecs [$];

   initial begin
      vec_t v;
      foreach (model_mem[i]) model_mem[i] = init_val(i);
      rst = 1'b1; cen = 1'b1; req = 1'b0; op_ptr = '0; op_mod = '0; op_wr = 1'b0; op_z = 1'b0;
      wr_data = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_din = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
      mem_clr = 1'b1;
      tick();
      mem_clr = 1'b0;
      tick();
      check("rst_addr", 32'(ram_addr), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_host_gnt", 32'(host_gnt), 32'd0);
      rst = 1'b0;

      // Single-cycle accesses: post-modify, VSR wrap, 16-bit wraparound, cfg priority
      vecs.push_back(cfgv(3'd0, 16'h0010));
      vecs.push_back(acc(2'd0, 2'b01, 1'b0, 16'h0, 11'h010));
      vecs.push_back(acc(2'd0, 2'b00, 1'b0, 16'h0, 11'h011));
      vecs.push_back(cfgv(3'd4, 16'h0020));
      vecs.push_back(cfgv(3'd5, 16'h0023));
      vecs.push_back(cfgv(3'd1, 16'h0023));
      vecs.push_back(acc(2'd1, 2'b01, 1'b0, 16'h0, 11'h023));
      vecs.push_back(acc(2'd1, 2'b00, 1'b0, 16'h0, 11'h020));
      vecs.push_back(cfgv(3'd5, 16'h0000));
      vecs.push_back(cfgv(3'd1, 16'h0023));
      vecs.push_back(acc(2'd1, 2'b01, 1'b0, 16'h0, 11'h023));
      vecs.push_back(acc(2'd1, 2'b00, 1'b0, 16'h0, 11'h024));
      vecs.push_back(cfgv(3'd6, 16'hFFFE));
      vecs.push_back(cfgv(3'd2, 16'h0001));
      vecs.push_back(acc(2'd2, 2'b11, 1'b1, 16'hBEEF, 11'h001));
      vecs.push_back(acc(2'd2, 2'b01, 1'b0, 16'h0, 11'h7FF));
      vecs.push_back(acc(2'd2, 2'b10, 1'b0, 16'h0, 11'h000));
      vecs.push_back(acc(2'd2, 2'b00, 1'b0, 16'h0, 11'h7FF));
      vecs.push_back(cfgv(3'd0, 16'h0001));
      vecs.push_back(acc(2'd0, 2'b00, 1'b0, 16'h0, 11'h001));
      vecs.push_back(cfgv(3'd3, 16'h0150));
      v = acc(2'd3, 2'b01, 1'b0, 16'h0, 11'h150);
      v.cfg = 1'b1; v.sel = 3'd3; v.din = 16'h0200;
      vecs.push_back(v);
      vecs.push_back(acc(2'd3, 2'b00, 1'b0, 16'h0, 11'h200));
      vecs.push_back(cfgv(3'd7, 16'h0555));
      vecs.push_back(acc(2'd3, 2'b00, 1'b0, 16'h0, 11'h200));
      vecs.push_back(cfgv(3'd5, 16'h0030));
      vecs.push_back(cfgv(3'd0, 16'h0030));
      vecs.push_back(acc(2'd0, 2'b10, 1'b0, 16'h0, 11'h030));
      vecs.push_back(acc(2'd0, 2'b00, 1'b0, 16'h0, 11'h02F));
      v = acc(2'd0, 2'b01, 1'b0, 16'h0, 11'h02F);
      v.cfg = 1'b1; v.sel = 3'd1; v.din = 16'h0077;
      vecs.push_back(v);
      vecs.push_back(acc(2'd1, 2'b00, 1'b0, 16'h0, 11'h077));
      vecs.push_back(acc(2'd0, 2'b01, 1'b0, 16'h0, 11'h030));
      vecs.push_back(acc(2'd0, 2'b00, 1'b0, 16'h0, 11'h020));

      foreach (vecs[i]) begin
         req = vecs[i].req; op_z = 1'b0; op_ptr = vecs[i].ptr; op_mod = vecs[i].mod;
         op_wr = vecs[i].wr; wr_data = vecs[i].wdata;
         cfg_we = vecs[i].cfg; cfg_sel = vecs[i].sel; cfg_din = vecs[i].din;
         if (vecs[i].req && !vecs[i].wr) sb.push_back(model_mem[vecs[i].exp_addr]);
         tick();
         check($sformatf("v%0d_we", i), 32'(ram_we), 32'(vecs[i].req && vecs[i].wr));
         if (vecs[i].req) begin
            check($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].wr) begin
               check($sformatf("v%0d_din", i), 32'(ram_din), 32'(vecs[i].wdata));
               model_mem[vecs[i].exp_addr] = vecs[i].wdata;
            end
         end
      end
      req = 1'b0; cfg_we = 1'b0;
      tick();

      // Compound read-then-write on r3
      cfg_ld(3'd3, 16'h0100);
      req = 1'b1; op_z = 1'b1; op_ptr = 2'd3; op_mod = 2'b01; wr_data = 16'h1234;
      sb.push_back(model_mem[11'h100]);
      tick();
      check("z1_addr", 32'(ram_addr), 32'h100);
      check("z1_we", 32'(ram_we), 32'd0);
      check("z1_busy", 32'(busy), 32'd1);
      tick();
      check("z2_addr", 32'(ram_addr), 32'h100);
      check("z2_we", 32'(ram_we), 32'd1);
      check("z2_din", 32'(ram_din), 32'h1234);
      check("z2_busy", 32'(busy), 32'd0);
      model_mem[11'h100] = 16'h1234;
      req = 1'b0; op_z = 1'b0;
      dsp_rd(2'd3, 2'b10, 11'h101);
      dsp_rd(2'd3, 2'b00, 11'h100);

`ifdef JTDSP16_RAM_HOST_EN
      // Host access in a spare slot, DSP request arriving during it
      host_req = 1'b1; host_we = 1'b0; host_addr = 11'h300;
      tick();
      check("h_gnt", 32'(host_gnt), 32'd1);
      check("h_addr", 32'(ram_addr), 32'h300);
      check("h_we", 32'(ram_we), 32'd0);
      req = 1'b1; op_ptr = 2'd0; op_mod = 2'b00; op_wr = 1'b0;
      #1;
      check("h_busy", 32'(busy), 32'd1);
      sb.push_back(model_mem[11'h020]);
      tick();
      check("h_stall_gnt", 32'(host_gnt), 32'd0);
      check("h_stall_addr", 32'(ram_addr), 32'h300);
      tick();
      check("h_dsp_addr", 32'(ram_addr), 32'h020);
      check("h_dsp_gnt", 32'(host_gnt), 32'd0);
      req = 1'b0; host_we = 1'b1; host_addr = 11'h301; host_din = 16'hCAFE;
      tick();
      check("hw_gnt", 32'(host_gnt), 32'd1);
      check("hw_we", 32'(ram_we), 32'd1);
      check("hw_din", 32'(ram_din), 32'hCAFE);
      model_mem[11'h301] = 16'hCAFE;
      host_req = 1'b0;
      tick();
      check("hw_gnt_end", 32'(host_gnt), 32'd0);
`else
      host_req = 1'b1; host_we = 1'b1; host_addr = 11'h302; host_din = 16'hCAFE;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("nohost_gnt", 32'(host_gnt), 32'd0);
         check("nohost_we", 32'(ram_we), 32'd0);
      end
      host_req = 1'b0;
`endif

      // Clock enable low holds everything
      cfg_ld(3'd0, 16'h0040);
      dsp_rd(2'd0, 2'b00, 11'h040);
      cfg_ld(3'd0, 16'h0045);
      cen = 1'b0; req = 1'b1; op_ptr = 2'd0; op_mod = 2'b01; op_wr = 1'b0;
      tick();
      tick();
      check("cen_hold_addr", 32'(ram_addr), 32'h040);
      cen = 1'b1;
      sb.push_back(model_mem[11'h045]);
      tick();
      check("cen_addr", 32'(ram_addr), 32'h045);
      req = 1'b0;
      dsp_rd(2'd0, 2'b00, 11'h046);

      // Reset while the compound write is pending
      cfg_ld(3'd0, 16'h0050);
      req = 1'b1; op_z = 1'b1; op_ptr = 2'd0; op_mod = 2'b01; wr_data = 16'hDEAD;
      tick();
      check("zr_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      check("zr_we", 32'(ram_we), 32'd0);
      check("zr_busy_clr", 32'(busy), 32'd0);
      check("zr_addr", 32'(ram_addr), 32'd0);
      rst = 1'b0; req = 1'b0; op_z = 1'b0;
      for (int p = 0; p < 4; p++) dsp_rd(2'(p), 2'b00, 11'h000);
      cfg_ld(3'd0, 16'h0050);
      dsp_rd(2'd0, 2'b00, 11'h050);

      for (int i = 0; i < 3; i++) tick();
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
